// File: rtl/div_err_monitor.sv
// Error-metric monitor for an approximate 16/8 divider: recomputes the exact quotient
// with a bit-serial restoring divider and accumulates MAE statistics for the host.
module div_err_monitor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] n,
    input  logic [7:0]  d,
    input  logic [7:0]  q_apx,
    output logic        busy,
    output logic        upd,
    output logic [31:0] sum_err,
    output logic [23:0] sample_cnt,
    output logic [23:0] mismatch_cnt,
    output logic [7:0]  max_err,
    output logic [15:0] oor_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic [7:0]  nlo_r;
    logic [7:0]  d_r;
    logic [7:0]  q_apx_r;
    logic [8:0]  rem_r;
    logic [7:0]  q_r;
    logic [2:0]  iter_r;
    logic        oor_r;
    logic        upd_r;
    logic [31:0] sum_err_r;
    logic [23:0] sample_cnt_r;
    logic [23:0] mismatch_cnt_r;
    logic [7:0]  max_err_r;
    logic [15:0] oor_cnt_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        oor_s;
    logic [8:0]  shifted_s;
    logic        qbit_s;
    logic [8:0]  rem_next_s;
    logic [7:0]  err_s;

    // Saturating adders: counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [7:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {25'd0, b};
        sat_add32 = s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [23:0] sat_inc24(input logic [23:0] a);
        sat_inc24 = (a == 24'hFF_FFFF) ? a : a + 24'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        sat_inc16 = (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

    assign in_ready_s = (state_r == S_IDLE) && !clr;
    assign accept_s   = in_valid && in_ready_s;
    // Quotient overflows 8 bits when the dividend's high byte already reaches the divisor.
    assign oor_s      = (d == 8'd0) || (n[15:8] >= d);

    assign shifted_s  = {rem_r[7:0], nlo_r[7]};
    assign qbit_s     = (shifted_s >= {1'b0, d_r});
    assign rem_next_s = qbit_s ? (shifted_s - {1'b0, d_r}) : shifted_s;
    assign err_s      = (q_r >= q_apx_r) ? (q_r - q_apx_r) : (q_apx_r - q_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; clr aborts whatever is in flight.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_s = oor_s ? S_ACC : S_DIV;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_DIV: begin
                    if (iter_r == 3'd7) begin
                        state_s = S_ACC;
                    end else begin
                        state_s = S_DIV;
                    end
                end
                S_ACC:   state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Handshake and status outputs.
    always_comb begin
        in_ready = in_ready_s;
        busy     = (state_r != S_IDLE);
    end

    // Capture, restoring-divide iterations and statistics accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nlo_r          <= 8'd0;
            d_r            <= 8'd0;
            q_apx_r        <= 8'd0;
            rem_r          <= 9'd0;
            q_r            <= 8'd0;
            iter_r         <= 3'd0;
            oor_r          <= 1'b0;
            upd_r          <= 1'b0;
            sum_err_r      <= 32'd0;
            sample_cnt_r   <= 24'd0;
            mismatch_cnt_r <= 24'd0;
            max_err_r      <= 8'd0;
            oor_cnt_r      <= 16'd0;
        end else if (clr) begin
            upd_r          <= 1'b0;
            sum_err_r      <= 32'd0;
            sample_cnt_r   <= 24'd0;
            mismatch_cnt_r <= 24'd0;
            max_err_r      <= 8'd0;
            oor_cnt_r      <= 16'd0;
        end else begin
            upd_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        nlo_r   <= n[7:0];
                        d_r     <= d;
                        q_apx_r <= q_apx;
                        rem_r   <= {1'b0, n[15:8]};
                        q_r     <= 8'd0;
                        iter_r  <= 3'd0;
                        oor_r   <= oor_s;
                    end
                end
                S_DIV: begin
                    rem_r  <= rem_next_s;
                    q_r    <= {q_r[6:0], qbit_s};
                    nlo_r  <= {nlo_r[6:0], 1'b0};
                    iter_r <= iter_r + 3'd1;
                end
                S_ACC: begin
                    upd_r <= 1'b1;
                    if (oor_r) begin
                        oor_cnt_r <= sat_inc16(oor_cnt_r);
                    end else begin
                        sum_err_r    <= sat_add32(sum_err_r, err_s);
                        sample_cnt_r <= sat_inc24(sample_cnt_r);
                        if (err_s != 8'd0) begin
                            mismatch_cnt_r <= sat_inc24(mismatch_cnt_r);
                        end
                        if (err_s > max_err_r) begin
                            max_err_r <= err_s;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign upd          = upd_r;
    assign sum_err      = sum_err_r;
    assign sample_cnt   = sample_cnt_r;
    assign mismatch_cnt = mismatch_cnt_r;
    assign max_err      = max_err_r;
    assign oor_cnt      = oor_cnt_r;

endmodule

// File: tb/tb_div_err_monitor.sv
// Randomised self-checking bench for div_err_monitor against an arithmetic reference model.
module tb_div_err_monitor;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q_apx;
    logic        busy;
    logic        upd;
    logic [31:0] sum_err;
    logic [23:0] sample_cnt;
    logic [23:0] mismatch_cnt;
    logic [7:0]  max_err;
    logic [15:0] oor_cnt;

    int tests;
    int fails;

    logic [31:0] m_sum;
    logic [23:0] m_cnt;
    logic [23:0] m_mis;
    logic [7:0]  m_max;
    logic [15:0] m_oor;

    div_err_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .n            (n),
        .d            (d),
        .q_apx        (q_apx),
        .busy         (busy),
        .upd          (upd),
        .sum_err      (sum_err),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .max_err      (max_err),
        .oor_cnt      (oor_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_oor(input logic [15:0] nv, input logic [7:0] dv);
        return (dv == 8'd0) || (int'(nv) / int'(dv) > 255);
    endfunction

    task automatic model_clear();
        m_sum = 32'd0; m_cnt = 24'd0; m_mis = 24'd0; m_max = 8'd0; m_oor = 16'd0;
    endtask

    task automatic model_apply(input logic [15:0] nv, input logic [7:0] dv, input logic [7:0] qv);
        longint s;
        int qe, e;
        if (is_oor(nv, dv)) begin
            if (m_oor != 16'hFFFF) m_oor = m_oor + 16'd1;
        end else begin
            qe = int'(nv) / int'(dv);
            e  = (qe > int'(qv)) ? qe - int'(qv) : int'(qv) - qe;
            s  = longint'(m_sum) + longint'(e);
            m_sum = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
            if (m_cnt != 24'hFF_FFFF) m_cnt = m_cnt + 24'd1;
            if (e != 0 && m_mis != 24'hFF_FFFF) m_mis = m_mis + 24'd1;
            if (e > int'(m_max)) m_max = 8'(e);
        end
    endtask

    // Present one sample, then count negedges until upd; ready_ok drops if the
    // monitor ever looks ready/idle before the update.
    task automatic send(input logic [15:0] nv, input logic [7:0] dv, input logic [7:0] qv,
                        output int lat, output bit ready_ok);
        @(negedge clk);
        n = nv; d = dv; q_apx = qv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 16'($urandom); d = 8'($urandom); q_apx = 8'($urandom);
        model_apply(nv, dv, qv);
        lat = 99;
        ready_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (upd) begin
                lat = k;
                if (!in_ready || busy) ready_ok = 1'b0;
                break;
            end
            if (in_ready || !busy) ready_ok = 1'b0;
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; n = 16'd0; d = 8'd0; q_apx = 8'd0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({sum_err, sample_cnt, mismatch_cnt, max_err, oor_cnt} !== {m_sum, m_cnt, m_mis, m_max, m_oor}) begin
            fails++;
            $display("FAIL reset_stats: got %h %h %h %h %h, want all zero", sum_err, sample_cnt, mismatch_cnt, max_err, oor_cnt);
        end
        tests++;
        if ({upd, busy, in_ready} !== 3'b001) begin
            fails++;
            $display("FAIL reset_ctrl: upd/busy/in_ready got %b, want 001", {upd, busy, in_ready});
        end
    endtask

    task automatic test_exact();
        int lat; bit rok;
        send(16'h0064, 8'h07, 8'h0E, lat, rok);
        tests++;
        if (lat !== 10) begin fails++; $display("FAIL exact_latency: got %0d want 10", lat); end
        tests++;
        if ({sum_err, sample_cnt, mismatch_cnt, max_err} !== {32'd0, 24'd1, 24'd0, 8'd0}) begin
            fails++;
            $display("FAIL exact_stats: got sum=%0d cnt=%0d mis=%0d max=%0d want 0 1 0 0", sum_err, sample_cnt, mismatch_cnt, max_err);
        end
    endtask

    task automatic test_err_accum();
        int lat1, lat2; bit rok1, rok2;
        do_clr();
        send(16'h0064, 8'h07, 8'h10, lat1, rok1);
        send(16'h00FF, 8'h01, 8'h00, lat2, rok2);
        tests++;
        if (lat1 !== 10 || lat2 !== 10) begin fails++; $display("FAIL accum_latency: got %0d %0d want 10 10", lat1, lat2); end
        tests++;
        if (!(rok1 && rok2)) begin fails++; $display("FAIL accum_ready: in_ready/busy got %b%b want 11 (no early ready)", rok1, rok2); end
        tests++;
        if ({sum_err, sample_cnt, mismatch_cnt, max_err} !== {32'd257, 24'd2, 24'd2, 8'hFF}) begin
            fails++;
            $display("FAIL accum_stats: got sum=%0d cnt=%0d mis=%0d max=%h want 257 2 2 ff", sum_err, sample_cnt, mismatch_cnt, max_err);
        end
    endtask

    task automatic test_oor();
        int lat1, lat2; bit rok1, rok2;
        send(16'h1234, 8'h00, 8'h55, lat1, rok1);
        tests++;
        if (lat1 !== 2 || oor_cnt !== 16'd1) begin fails++; $display("FAIL oor_div0: got lat=%0d oor=%0d want 2 1", lat1, oor_cnt); end
        send(16'h0800, 8'h08, 8'h00, lat2, rok2);
        tests++;
        if (lat2 !== 2 || oor_cnt !== 16'd2) begin fails++; $display("FAIL oor_hi: got lat=%0d oor=%0d want 2 2", lat2, oor_cnt); end
        tests++;
        if ({sum_err, sample_cnt, mismatch_cnt, max_err} !== {m_sum, m_cnt, m_mis, m_max}) begin
            fails++;
            $display("FAIL oor_others: got %h %h %h %h want %h %h %h %h", sum_err, sample_cnt, mismatch_cnt, max_err, m_sum, m_cnt, m_mis, m_max);
        end
    endtask

    task automatic test_abort();
        int lat; bit rok; bit saw_upd;
        @(negedge clk);
        n = 16'h0064; d = 8'h07; q_apx = 8'h11; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        @(negedge clk);
        tests++;
        if ({busy, in_ready, upd} !== 3'b010) begin fails++; $display("FAIL abort_idle: busy/in_ready/upd got %b want 010", {busy, in_ready, upd}); end
        tests++;
        if ({sum_err, sample_cnt, mismatch_cnt, max_err, oor_cnt} !== 104'd0) begin
            fails++;
            $display("FAIL abort_stats: got %h %h %h %h %h want zero", sum_err, sample_cnt, mismatch_cnt, max_err, oor_cnt);
        end
        saw_upd = 1'b0;
        repeat (12) begin @(negedge clk); if (upd) saw_upd = 1'b1; end
        tests++;
        if (saw_upd !== 1'b0) begin fails++; $display("FAIL abort_no_upd: got upd pulse, want none"); end
        send(16'h0064, 8'h07, 8'h11, lat, rok);
        tests++;
        if (sum_err !== 32'd3 || lat !== 10) begin fails++; $display("FAIL abort_resume: got sum=%0d lat=%0d want 3 10", sum_err, lat); end
    endtask

    task automatic test_clr_vs_valid();
        bit saw;
        @(negedge clk);
        n = 16'h0064; d = 8'h07; q_apx = 8'h00; in_valid = 1'b1; clr = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL clr_ready: in_ready got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; clr = 1'b0;
        model_clear();
        saw = 1'b0;
        repeat (12) begin @(negedge clk); if (upd || busy) saw = 1'b1; end
        tests++;
        if (saw !== 1'b0 || sample_cnt !== m_cnt) begin fails++; $display("FAIL clr_wins: got activity=%b cnt=%0d want 0 0", saw, sample_cnt); end
    endtask

    task automatic test_saturation();
        int lat; bit rok;
        do_clr();
        @(negedge clk);
        force dut.sum_err_r = 32'hFFFF_FFF0;
        #1;
        release dut.sum_err_r;
        m_sum = 32'hFFFF_FFF0;
        send(16'h0040, 8'h01, 8'h20, lat, rok);
        tests++;
        if (sum_err !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_sum: got %h want ffffffff", sum_err); end
        tests++;
        if ({sample_cnt, mismatch_cnt, max_err} !== {m_cnt, m_mis, m_max}) begin
            fails++;
            $display("FAIL sat_others: got %0d %0d %h want %0d %0d %h", sample_cnt, mismatch_cnt, max_err, m_cnt, m_mis, m_max);
        end
    endtask

    task automatic test_random();
        int lat, exp_lat, qe;
        bit rok;
        logic [15:0] nv;
        logic [7:0]  dv, qv;
        do_clr();
        for (int i = 0; i < 40; i++) begin
            dv = 8'($urandom_range(0, 255));
            nv = 16'($urandom);
            if (dv != 8'd0 && $urandom_range(0, 3) != 0) nv[15:8] = 8'(int'(nv[15:8]) % int'(dv));
            if (is_oor(nv, dv)) begin
                qv = 8'($urandom);
            end else begin
                qe = int'(nv) / int'(dv);
                qv = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(qe + int'($urandom_range(0, 6)) - 3);
            end
            exp_lat = is_oor(nv, dv) ? 2 : 10;
            send(nv, dv, qv, lat, rok);
            tests++;
            if (lat !== exp_lat || !rok) begin
                fails++;
                $display("FAIL rand_timing[%0d]: n=%h d=%h got lat=%0d ready_ok=%b want %0d 1", i, nv, dv, lat, rok, exp_lat);
            end
            tests++;
            if ({sum_err, sample_cnt, mismatch_cnt, max_err, oor_cnt} !== {m_sum, m_cnt, m_mis, m_max, m_oor}) begin
                fails++;
                $display("FAIL rand_stats[%0d]: n=%h d=%h q=%h got %h %h %h %h %h want %h %h %h %h %h", i, nv, dv, qv,
                         sum_err, sample_cnt, mismatch_cnt, max_err, oor_cnt, m_sum, m_cnt, m_mis, m_max, m_oor);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_exact();
        test_err_accum();
        test_oor();
        test_abort();
        test_clr_vs_valid();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
